// File: rtl/mat2_mul_seq.sv
// Sequential 2x2 signed matrix multiplier: streams in A then B, runs one
// shared multiply-accumulate per cycle, then streams out the clamped C elements.
module mat2_mul_seq #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sat,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high; the producer holds its payload stable until that edge.

  localparam int W  = DATA_WIDTH;
  localparam int AW = 2 * DATA_WIDTH + 1;

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic signed [AW-1:0] SAT_MAX = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(W+2){1'b1}}, {(W-1){1'b0}}};

  logic [1:0]               state;
  logic [2:0]               load_cnt;
  logic [2:0]               mac_cnt;
  logic [1:0]               out_cnt;
  logic                     armed;
  logic signed [W-1:0]      opa [4];
  logic signed [W-1:0]      opb [4];
  logic signed [AW-1:0]     acc;
  logic [W-1:0]             res [4];
  logic [3:0]               res_sat;

  logic                     in_fire;
  logic                     out_fire;
  logic [1:0]               elem;
  logic                     term;
  logic [1:0]               a_idx;
  logic [1:0]               b_idx;
  logic signed [2*W-1:0]    prod;
  logic signed [AW-1:0]     prod_ext;
  logic signed [AW-1:0]     sum;
  logic [W-1:0]             clamped;
  logic                     clamp_hit;

  // armed keeps in_ready low until the first edge after reset release
  assign in_ready  = (state == S_LOAD) && armed;
  assign out_valid = (state == S_OUT);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign busy      = (state != S_LOAD) || (load_cnt != 3'd0);
  assign dbg_state = state;

  assign out_data  = out_valid ? res[out_cnt] : '0;
  assign out_sat   = out_valid ? res_sat[out_cnt] : 1'b0;

  // mac_cnt = {element, term}: c_ij term k uses a[i][k] * b[k][j]
  assign elem  = mac_cnt[2:1];
  assign term  = mac_cnt[0];
  assign a_idx = {elem[1], term};
  assign b_idx = {term, elem[0]};

  always_comb begin
    prod      = opa[a_idx] * opb[b_idx];
    prod_ext  = {prod[2*W-1], prod};
    sum       = acc + prod_ext;
    clamped   = sum[W-1:0];
    clamp_hit = 1'b0;
    if (sum > SAT_MAX) begin
      clamped   = SAT_MAX[W-1:0];
      clamp_hit = 1'b1;
    end else if (sum < SAT_MIN) begin
      clamped   = SAT_MIN[W-1:0];
      clamp_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_LOAD;
      load_cnt <= 3'd0;
      mac_cnt  <= 3'd0;
      out_cnt  <= 2'd0;
    end else begin
      case (state)
        S_LOAD: begin
          if (in_fire) begin
            if (load_cnt == 3'd7) begin
              state    <= S_MAC;
              load_cnt <= 3'd0;
              mac_cnt  <= 3'd0;
            end else begin
              load_cnt <= load_cnt + 3'd1;
            end
          end
        end
        S_MAC: begin
          mac_cnt <= mac_cnt + 3'd1;
          if (mac_cnt == 3'd7) begin
            state   <= S_OUT;
            out_cnt <= 2'd0;
          end
        end
        S_OUT: begin
          if (out_fire) begin
            out_cnt <= out_cnt + 2'd1;
            if (out_cnt == 2'd3) begin
              state <= S_LOAD;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  // Operand capture: first four transfers fill A, last four fill B
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        opa[i] <= '0;
        opb[i] <= '0;
      end
    end else if (in_fire) begin
      if (load_cnt[2]) begin
        opb[load_cnt[1:0]] <= in_data;
      end else begin
        opa[load_cnt[1:0]] <= in_data;
      end
    end
  end

  // Term 0 seeds the accumulator; term 1 completes, clamps and stores the element
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      res_sat <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        res[i] <= '0;
      end
    end else if (state == S_MAC) begin
      if (!term) begin
        acc <= prod_ext;
      end else begin
        acc           <= sum;
        res[elem]     <= clamped;
        res_sat[elem] <= clamp_hit;
      end
    end
  end

endmodule

// File: tb/tb_mat2_mul_seq.sv
// Directed bench for mat2_mul_seq: expected C elements are queued when a pair is
// sent and compared by a negedge monitor when the DUT hands them out.
module tb_mat2_mul_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_sat;
  logic         busy;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  logic [W:0] exp_q[$];

  mat2_mul_seq #(.DATA_WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input int s);
    int           mx;
    int           mn;
    logic [W-1:0] d;
    mx = (1 << (W - 1)) - 1;
    mn = -(1 << (W - 1));
    if (s > mx) begin
      d = W'(mx);
      return {1'b1, d};
    end else if (s < mn) begin
      d = W'(mn);
      return {1'b1, d};
    end
    d = W'(s);
    return {1'b0, d};
  endfunction

  // driver tasks: entered and left at posedge+#1
  task automatic send_elem(input int x, input int gap);
    bit took;
    int n;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = W'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = W'(x);
    n = 0;
    forever begin
      took = in_ready;
      @(posedge clk); #1;
      if (took) break;
      n++;
      if (n > 300) begin
        chk("in_timeout", 32'(n), 32'(0));
        break;
      end
    end
    in_valid = 1'b0;
    in_data  = W'($urandom);
  endtask

  task automatic send_pair(input int a[4], input int b[4], input int gmax);
    int s;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = a[i*2] * b[j] + a[i*2+1] * b[2+j];
        exp_q.push_back(model(s));
      end
    end
    for (int k = 0; k < 4; k++) send_elem(a[k], $urandom_range(0, gmax));
    for (int k = 0; k < 4; k++) send_elem(b[k], $urandom_range(0, gmax));
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'(0));
    chk({tag, "_ready_after"}, 32'(in_ready), 32'(1));
  endtask

  // scoreboard monitor
  logic       stall_q = 1'b0;
  logic [W:0] held_q  = '0;
  always @(negedge clk) begin
    if (out_valid) begin
      if (stall_q) chk("hold_stable", 32'({out_sat, out_data}), 32'(held_q));
      chk("no_in_during_out", 32'(in_ready), 32'(0));
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'({out_sat, out_data}), 32'hFFFF_FFFF);
        end else begin
          chk("out_elem", 32'({out_sat, out_data}), 32'(exp_q.pop_front()));
        end
      end
    end else begin
      chk("idle_zero", 32'(out_data), 32'(0));
    end
    stall_q <= rst_n && out_valid && !out_ready;
    held_q  <= {out_sat, out_data};
  end

  initial begin
    int ra[4];
    int rb[4];
    int n;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_out_sat", 32'(out_sat), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_low", 32'(in_ready), 32'(0));
    @(posedge clk); #1;
    chk("rel_in_ready_high", 32'(in_ready), 32'(1));

    // identity, with exact latency check
    out_ready = 1'b1;
    send_pair('{1, 2, 3, 4}, '{1, 0, 0, 1}, 0);
    chk("busy_mac", 32'(busy), 32'(1));
    chk("in_ready_mac", 32'(in_ready), 32'(0));
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("latency_e%0d", k), 32'(out_valid), 32'(k == 8));
    end
    wait_drain("identity");

    send_pair('{-3, 5, 2, -1}, '{4, -2, 7, 6}, 0);
    wait_drain("signed");

    send_pair('{127, 127, -128, -128}, '{127, 0, 127, 0}, 0);
    wait_drain("sat");

    send_pair('{-128, -128, -128, -128}, '{-128, -128, -128, -128}, 0);
    wait_drain("sat_max_sum");

    // backpressure
    out_ready = 1'b0;
    send_pair('{-3, 5, 2, -1}, '{4, -2, 7, 6}, 1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_out_valid", 32'(out_valid), 32'(1));
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_stall_valid", 32'(out_valid), 32'(1));
      chk("bp_stall_count", 32'(exp_q.size()), 32'(4));
    end
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      if (exp_q.size() != 0) chk("bp_in_ready", 32'(in_ready), 32'(0));
      out_ready = !out_ready;
      n++;
    end
    chk("bp_drain", 32'(exp_q.size()), 32'(0));
    chk("bp_ready_after", 32'(in_ready), 32'(1));
    out_ready = 1'b1;

    // reset in the middle of the MAC phase
    send_pair('{9, 9, 9, 9}, '{9, 9, 9, 9}, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_in_ready", 32'(in_ready), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_out_data", 32'(out_data), 32'(0));
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ready_back", 32'(in_ready), 32'(1));
    send_pair('{-3, 5, 2, -1}, '{4, -2, 7, 6}, 0);
    wait_drain("after_rst");

    // back-to-back random pairs with input gaps
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 4; k++) begin
        ra[k] = int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
        rb[k] = int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
      end
      send_pair(ra, rb, 2);
    end
    wait_drain("b2b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed timeout expected completion");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/mat2_mul_seq.md
MAT2_MUL_SEQ -- requirements
Module: mat2_mul_seq

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, element width in bits; elements are signed two's complement.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  in_data holds a valid element.
REQ-005 in_ready  output  1  block accepts an element; a transfer occurs on an edge where in_valid && in_ready.
REQ-006 in_data  input  DATA_WIDTH  operand element, serial order a00,a01,a10,a11,b00,b01,b10,b11.
REQ-007 out_valid  output  1  out_data/out_sat hold a valid result element.
REQ-008 out_ready  input  1  consumer accepts; a transfer occurs on an edge where out_valid && out_ready.
REQ-009 out_data  output  DATA_WIDTH  result element, serial order c00,c01,c10,c11.
REQ-010 out_sat  output  1  current out_data was clamped.
REQ-011 busy  output  1  a matrix pair is partially loaded, computing, or unloading.

Function
REQ-012 Block SHALL compute C = A*B: c_ij = a_i0*b_0j + a_i1*b_1j.
REQ-013 FSM states SHALL be LOAD, MAC, OUT; in_ready=1 only in LOAD; out_valid=1 only in OUT.
REQ-014 LOAD: 3-bit counter increments per input transfer; the 8th transfer (count 7) SHALL move to MAC and clear the counter.
REQ-015 MAC: one shared multiplier, exactly one product per cycle, 8 cycles total, order c00 p0,p1, c01 p0,p1, c10 p0,p1, c11 p0,p1.
REQ-016 Accumulator SHALL be 2*DATA_WIDTH+1 bits, signed; no intermediate truncation.
REQ-017 Each completed sum SHALL be clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; its sat flag set iff clamping occurred.
REQ-018 out_valid SHALL assert on the 8th edge after the edge accepting the 8th input (fixed latency 8, independent of data).
REQ-019 OUT: out_data/out_sat SHALL hold stable while out_valid && !out_ready; each output transfer advances to the next element.
REQ-020 After the 4th output transfer, SHALL return to LOAD with in_ready=1 on the next cycle; no inputs accepted during MAC/OUT.
REQ-021 in_data presented while in_ready=0 SHALL be ignored and SHALL not affect results.
REQ-022 in_valid gaps during LOAD SHALL stall the counter without corrupting already-loaded elements.
REQ-023 busy SHALL equal (state != LOAD) || (load count != 0).
REQ-024 out_data SHALL be 0 whenever out_valid=0.

Reset
REQ-025 rst_n low SHALL immediately force state LOAD, counters 0, accumulator and operand/result registers 0.
REQ-026 Reset values: in_ready=0, out_valid=0, out_data=0, out_sat=0, busy=0; in_ready rises on the first edge with rst_n high.
REQ-027 Reset mid-LOAD, mid-MAC or mid-OUT SHALL discard the partial operation; the next 8 inputs form a fresh pair.

Verification
REQ-028 Identity: A=[1,2,3,4], B=[1,0,0,1] -> out 1,2,3,4, out_sat 0,0,0,0, out_valid 8 cycles after last input.
REQ-029 Signed: A=[-3,5,2,-1], B=[4,-2,7,6] -> out 23,36,1,-10, out_sat all 0.
REQ-030 Saturation: A=[127,127,-128,-128], B=[127,0,127,0] -> out 127,0,-128,0; out_sat 1,0,1,0.
REQ-031 Backpressure: out_ready low 5 cycles at c00, then toggled every other cycle -> each element held stable, emitted once, in order; in_ready stays 0 until the 4th transfer.
REQ-032 Reset mid-MAC: pulse rst_n low during MAC cycle 4 -> all outputs 0 immediately; the following load of the REQ-029 operands yields 23,36,1,-10.
REQ-033 Back-to-back: in_valid held high with three pairs and random in_valid gaps -> three correct 4-element results in order; no input accepted outside LOAD.
